// File: rtl/enc_pkg.sv
// Shared types and constants for the serial 8-to-3 encoder.
// Also holds a popcount helper used for the pending-code count.
package enc_pkg;

  localparam int DATA_W = 8;
  localparam int CODE_W = 3;
  localparam int CNT_W  = 4;

  localparam bit PRI_LSB = 1'b0;
  localparam bit PRI_MSB = 1'b1;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_e;

  function automatic logic [CNT_W-1:0] popcount(input logic [DATA_W-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DATA_W; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/serial_encoder_8x3_if.sv
// Bitmap-in / code-out handshake bundle for serial_encoder_8x3.
// The master side feeds bitmaps and accepts codes; the slave side is the encoder.
interface serial_encoder_8x3_if;

  logic [enc_pkg::DATA_W-1:0] data_in;
  logic                       data_valid;
  logic                       data_ready;
  logic [enc_pkg::CODE_W-1:0] code;
  logic                       code_valid;
  logic                       code_ready;
  logic                       code_last;
  logic [enc_pkg::CNT_W-1:0]  pend_cnt;
  logic                       zero_err;

  modport master (
    output data_in, data_valid, code_ready,
    input  data_ready, code, code_valid, code_last, pend_cnt, zero_err
  );

  modport slave (
    input  data_in, data_valid, code_ready,
    output data_ready, code, code_valid, code_last, pend_cnt, zero_err
  );

endinterface

// File: rtl/prio_enc8.sv
// Combinational 8-bit priority encoder: index of the lowest set bit,
// or the highest when msb_first is set; any flags a non-empty vector.
module prio_enc8
  import enc_pkg::*;
(
  input  logic [DATA_W-1:0] vec,
  input  logic              msb_first,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  // Later loop iterations overwrite earlier ones, so the scan direction
  // is chosen so that the winning bit is visited last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    idx = '0;
    any = |vec;
    if (msb_first) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (vec[i]) idx = CODE_W'(i);
      end
    end else begin
      for (int i = DATA_W - 1; i >= 0; i--) begin
        if (vec[i]) idx = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/serial_encoder_8x3.sv
// Sequential 8-to-3 encoder: accepts a request bitmap and streams out the
// index of every set bit, one per code handshake, in fixed priority order.
module serial_encoder_8x3
  import enc_pkg::*;
#(
  parameter bit PRIORITY = PRI_LSB
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_encoder_8x3_if.slave  bus
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   pending_q, pending_d;
  logic                zero_err_q, zero_err_d;

  logic [CODE_W-1:0]   enc_idx;
  logic                enc_any;
  logic [CODE_W-1:0]   code_int;
  logic [DATA_W-1:0]   clr_mask;
  logic [CNT_W-1:0]    cnt_int;
  logic                busy;
  logic                ready_int;

  prio_enc8 u_prio (
    .vec       (pending_q),
    .msb_first (PRIORITY == PRI_MSB),
    .idx       (enc_idx),
    .any       (enc_any)
  );

  // All code-side outputs come from registered state only.
  assign busy      = (state_q == ST_BUSY);
  assign code_int  = (busy && enc_any) ? enc_idx : '0;
  assign cnt_int   = popcount(pending_q);
  assign clr_mask  = {{(DATA_W-1){1'b0}}, 1'b1} << code_int;
  assign ready_int = (state_q == ST_IDLE) && !rst;

  assign bus.data_ready = ready_int;
  assign bus.code       = code_int;
  assign bus.code_valid = busy;
  assign bus.code_last  = busy && (cnt_int == CNT_W'(1));
  assign bus.pend_cnt   = cnt_int;
  assign bus.zero_err   = zero_err_q;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    zero_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.data_valid && ready_int) begin
          if (bus.data_in != '0) begin
            pending_d = bus.data_in;
            state_d   = ST_BUSY;
          end else begin
            zero_err_d = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (bus.code_ready) begin
          pending_d = pending_q & ~clr_mask;
          if (cnt_int == CNT_W'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it sits inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      zero_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      zero_err_q <= zero_err_d;
    end
  end

endmodule

// File: tb/tb_serial_encoder_8x3.sv
// Directed bench for serial_encoder_8x3: a per-cycle vector table for the
// LSB-first instance plus hand-written MSB-first, 8'hFF and reset sequences.
module tb_serial_encoder_8x3;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  serial_encoder_8x3_if if_lsb ();
  serial_encoder_8x3_if if_msb ();

  serial_encoder_8x3 #(.PRIORITY(1'b0)) dut_lsb (.clk(clk), .rst(rst), .bus(if_lsb));
  serial_encoder_8x3 #(.PRIORITY(1'b1)) dut_msb (.clk(clk), .rst(rst), .bus(if_msb));

  typedef struct {
    logic       rst;
    logic       dv;
    logic [7:0] din;
    logic       cr;
    logic       rdy;
    logic       vld;
    logic [2:0] code;
    logic       last;
    logic [3:0] cnt;
    logic       zerr;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_lsb(input string tag, input logic rdy, input logic vld,
                           input logic [2:0] code, input logic last,
                           input logic [3:0] cnt, input logic zerr);
    check({tag, " data_ready"}, 32'(if_lsb.data_ready), 32'(rdy));
    check({tag, " code_valid"}, 32'(if_lsb.code_valid), 32'(vld));
    check({tag, " code"},       32'(if_lsb.code),       32'(code));
    check({tag, " code_last"},  32'(if_lsb.code_last),  32'(last));
    check({tag, " pend_cnt"},   32'(if_lsb.pend_cnt),   32'(cnt));
    check({tag, " zero_err"},   32'(if_lsb.zero_err),   32'(zerr));
  endtask

  task automatic check_msb(input string tag, input logic rdy, input logic vld,
                           input logic [2:0] code, input logic last, input logic [3:0] cnt);
    check({tag, " data_ready"}, 32'(if_msb.data_ready), 32'(rdy));
    check({tag, " code_valid"}, 32'(if_msb.code_valid), 32'(vld));
    check({tag, " code"},       32'(if_msb.code),       32'(code));
    check({tag, " code_last"},  32'(if_msb.code_last),  32'(last));
    check({tag, " pend_cnt"},   32'(if_msb.pend_cnt),   32'(cnt));
  endtask

  task automatic drive_lsb(input logic r, input logic dv, input logic [7:0] din, input logic cr);
    rst               = r;
    if_lsb.data_valid = dv;
    if_lsb.data_in    = din;
    if_lsb.code_ready = cr;
  endtask

  // Inputs are driven just after a rising edge; outputs are sampled at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            rst dv din    cr  rdy vld code last cnt zerr
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'hA4, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 4'd3, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 4'd2, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd7, 1'b1, 4'd1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'h81, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'd2, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'd2, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'd2, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 4'd2, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd7, 1'b1, 4'd1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 8'h40, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 4'd2, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 8'h40, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 4'd1, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 8'h40, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd6, 1'b1, 4'd1, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0};

    drive_lsb(1'b1, 1'b0, 8'h00, 1'b1);
    if_msb.data_valid = 1'b0;
    if_msb.data_in    = 8'h00;
    if_msb.code_ready = 1'b1;
    repeat (2) next_cycle();

    // Main table on the LSB-first instance.
    for (int i = 0; i < 22; i++) begin
      drive_lsb(vecs[i].rst, vecs[i].dv, vecs[i].din, vecs[i].cr);
      @(negedge clk);
      check_lsb($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].vld, vecs[i].code,
                vecs[i].last, vecs[i].cnt, vecs[i].zerr);
      next_cycle();
    end
    drive_lsb(1'b0, 1'b0, 8'h00, 1'b1);

    // MSB-first ordering of 8'b1010_0100.
    if_msb.data_valid = 1'b1;
    if_msb.data_in    = 8'hA4;
    @(negedge clk);
    check_msb("msb accept", 1'b1, 1'b0, 3'd0, 1'b0, 4'd0);
    next_cycle();
    if_msb.data_valid = 1'b0;
    @(negedge clk);
    check_msb("msb c0", 1'b0, 1'b1, 3'd7, 1'b0, 4'd3);
    next_cycle();
    @(negedge clk);
    check_msb("msb c1", 1'b0, 1'b1, 3'd5, 1'b0, 4'd2);
    next_cycle();
    @(negedge clk);
    check_msb("msb c2", 1'b0, 1'b1, 3'd2, 1'b1, 4'd1);
    next_cycle();
    @(negedge clk);
    check_msb("msb idle", 1'b1, 1'b0, 3'd0, 1'b0, 4'd0);
    next_cycle();

    // Full bitmap: eight codes, count 8 down to 1, last on the eighth.
    drive_lsb(1'b0, 1'b1, 8'hFF, 1'b1);
    next_cycle();
    drive_lsb(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_lsb($sformatf("ff code%0d", i), 1'b0, 1'b1, 3'(i), (i == 7), 4'(8 - i), 1'b0);
      next_cycle();
    end
    @(negedge clk);
    check_lsb("ff idle", 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0);
    next_cycle();

    // Reset in the middle of an 8'hFF burst, after three code handshakes.
    drive_lsb(1'b0, 1'b1, 8'hFF, 1'b1);
    next_cycle();
    drive_lsb(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_lsb($sformatf("rst burst code%0d", i), 1'b0, 1'b1, 3'(i), 1'b0, 4'(8 - i), 1'b0);
      next_cycle();
    end
    drive_lsb(1'b1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check_lsb("rst asserted", 1'b0, 1'b1, 3'd3, 1'b0, 4'd5, 1'b0);
    next_cycle();
    drive_lsb(1'b0, 1'b1, 8'h10, 1'b1);
    @(negedge clk);
    check_lsb("post rst", 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0);
    next_cycle();
    drive_lsb(1'b0, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    check_lsb("post rst code4", 1'b0, 1'b1, 3'd4, 1'b1, 4'd1, 1'b0);
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_lsb($sformatf("post rst quiet%0d", i), 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0);
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
